// File: rtl/ss_stack.sv
// Register-cached data stack: TOS and second-on-stack in flops, deeper entries in a
// circular memory addressed by sp. Single-cycle PUSH/POP/LOAD/PICK with sticky error flags.
module ss_stack #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DSZ   = 32,
  localparam int unsigned SSZ  = $clog2(DEPTH),
  localparam int unsigned CSZ  = SSZ + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [SSZ-1:0] sp,
  output logic [DSZ-1:0] s0,
  output logic [DSZ-1:0] tos,
  output logic [CSZ-1:0] depth,
  output logic           ovf,
  output logic           unf
);

  typedef enum logic [1:0] {
    SS_PICK = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2,
    SS_LOAD = 2'd3
  } sop_e;

  sop_e op_e;
  assign op_e = sop_e'(op);

  logic [DSZ-1:0] mem_q [DEPTH];

  logic [DSZ-1:0] tos_q, tos_d;
  logic [DSZ-1:0] s0_q, s0_d;
  logic [SSZ-1:0] sp_q, sp_d;
  logic [CSZ-1:0] depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic [SSZ-1:0] sp_inc, sp_dec, pick_n, pick_addr, rd_addr;
  logic [DSZ-1:0] mem_rd;
  logic           mem_we;
  logic           depth_full, depth_empty, pick_oob;

  assign sp_inc      = sp_q + SSZ'(1);
  assign sp_dec      = sp_q - SSZ'(1);
  assign pick_n      = vi[SSZ-1:0];
  assign pick_addr   = sp_q - pick_n;
  assign depth_full  = (depth_q == CSZ'(DEPTH));
  assign depth_empty = (depth_q == '0);
  assign pick_oob    = ({1'b0, pick_n} >= depth_q);

  // One shared read port: POP fetches the new s0, PICK fetches the picked entry.
  always_comb begin
    rd_addr = (op_e == SS_POP) ? sp_dec : pick_addr;
    mem_rd  = mem_q[rd_addr];
  end

  always_comb begin
    tos_d   = tos_q;
    s0_d    = s0_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    mem_we  = 1'b0;
    if (en) begin
      unique case (op_e)
        SS_PUSH: begin
          mem_we = 1'b1;
          sp_d   = sp_inc;
          s0_d   = tos_q;
          tos_d  = vi;
          if (depth_full) begin
            ovf_d = 1'b1;
          end else begin
            depth_d = depth_q + CSZ'(1);
          end
        end
        SS_POP: begin
          tos_d = s0_q;
          s0_d  = mem_rd;
          sp_d  = sp_dec;
          if (depth_empty) begin
            unf_d = 1'b1;
          end else begin
            depth_d = depth_q - CSZ'(1);
          end
        end
        SS_LOAD: begin
          tos_d = vi;
        end
        SS_PICK: begin
          // Index 0 is s0 itself; use the register since mem[sp] is not valid after reset.
          tos_d = (pick_n == '0) ? s0_q : mem_rd;
          if (pick_oob) begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q   <= '1;
      s0_q    <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      s0_q    <= s0_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Memory contents are undefined after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[sp_inc] <= tos_q;
    end
  end

  assign sp    = sp_q;
  assign s0    = s0_q;
  assign tos   = tos_q;
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_ss_stack.sv
// Randomised bench for ss_stack: a plain array model of the stack is checked every cycle,
// plus directed sequences with literal expectations.
module tb_ss_stack;

  localparam int unsigned D   = 8;
  localparam int unsigned DSZ = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [1:0]     op;
  logic [DSZ-1:0] vi;
  logic [2:0]     sp;
  logic [DSZ-1:0] s0;
  logic [DSZ-1:0] tos;
  logic [3:0]     depth;
  logic           ovf;
  logic           unf;

  ss_stack #(.DEPTH(D), .DSZ(DSZ)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .op   (op),
    .vi   (vi),
    .sp   (sp),
    .s0   (s0),
    .tos  (tos),
    .depth(depth),
    .ovf  (ovf),
    .unf  (unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state; *_k flags mark values that are defined (not from never-written memory).
  logic [31:0] m_mem [D];
  bit          m_mk  [D];
  logic [31:0] m_tos, m_s0;
  bit          m_tos_k, m_s0_k;
  int          m_sp, m_depth;
  bit          m_ovf, m_unf;
  bit          chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tos = 32'hFFFF_FFFF; m_tos_k = 1'b1;
    m_s0  = 32'h0;         m_s0_k  = 1'b1;
    m_sp = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < D; i++) m_mk[i] = 1'b0;
  endtask

  task automatic model_step(input bit e, input logic [1:0] o, input logic [31:0] v);
    int a;
    int n;
    if (!e) return;
    case (o)
      2'd1: begin
        a = (m_sp + 1) % D;
        m_mem[a] = m_tos; m_mk[a] = m_tos_k;
        m_s0 = m_tos; m_s0_k = m_tos_k;
        m_tos = v; m_tos_k = 1'b1;
        m_sp = a;
        if (m_depth == D) m_ovf = 1'b1; else m_depth++;
      end
      2'd2: begin
        a = (m_sp + D - 1) % D;
        m_tos = m_s0; m_tos_k = m_s0_k;
        m_s0 = m_mem[a]; m_s0_k = m_mk[a];
        m_sp = a;
        if (m_depth == 0) m_unf = 1'b1; else m_depth--;
      end
      2'd3: begin
        m_tos = v; m_tos_k = 1'b1;
      end
      default: begin
        n = int'(v % D);
        if (n == 0) begin
          m_tos = m_s0; m_tos_k = m_s0_k;
        end else begin
          a = (m_sp - n + D) % D;
          m_tos = m_mem[a]; m_tos_k = m_mk[a];
        end
        if (n >= m_depth) m_unf = 1'b1;
      end
    endcase
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("sp", 64'(sp), 64'(m_sp));
      check("depth", 64'(depth), 64'(m_depth));
      check("ovf", 64'(ovf), 64'(m_ovf));
      check("unf", 64'(unf), 64'(m_unf));
      if (m_tos_k) check("tos", 64'(tos), 64'(m_tos));
      if (m_s0_k) check("s0", 64'(s0), 64'(m_s0));
    end
  end

  task automatic do_op(input bit e, input logic [1:0] o, input logic [31:0] v);
    en = e; op = o; vi = v;
    @(posedge clk);
    model_step(e, o, v);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1; en = 1'b0;
    #1 model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 2'd0; vi = '0;
    model_reset();
    chk_on = 1'b1;
    #1;
    check("rst_tos", 64'(tos), 64'hFFFF_FFFF);
    check("rst_s0", 64'(s0), 64'h0);
    check("rst_sp", 64'(sp), 64'h0);
    check("rst_depth", 64'(depth), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Three pushes
    do_op(1, 2'd1, 32'h11);
    do_op(1, 2'd1, 32'h22);
    do_op(1, 2'd1, 32'h33);
    check("p3_tos", 64'(tos), 64'h33);
    check("p3_s0", 64'(s0), 64'h22);
    check("p3_sp", 64'(sp), 64'd3);
    check("p3_depth", 64'(depth), 64'd3);
    check("p3_flags", 64'({ovf, unf}), 64'd0);
    do_op(0, 2'd2, 32'h0);
    check("idle_tos", 64'(tos), 64'h33);
    do_op(1, 2'd2, 32'h0);
    check("pop1_tos", 64'(tos), 64'h22);
    check("pop1_s0", 64'(s0), 64'h11);
    check("pop1_sp", 64'(sp), 64'd2);
    do_op(1, 2'd2, 32'h0);
    check("pop2_tos", 64'(tos), 64'h11);
    check("pop2_s0", 64'(s0), 64'hFFFF_FFFF);
    check("pop2_sp", 64'(sp), 64'd1);
    check("pop2_depth", 64'(depth), 64'd1);

    // Pick and load
    do_reset();
    do_op(1, 2'd1, 32'h11);
    do_op(1, 2'd1, 32'h22);
    do_op(1, 2'd1, 32'h33);
    do_op(1, 2'd0, 32'd1);
    check("pick1_tos", 64'(tos), 64'h11);
    check("pick1_sp", 64'(sp), 64'd3);
    check("pick1_depth", 64'(depth), 64'd3);
    check("pick1_unf", 64'(unf), 64'd0);
    do_op(1, 2'd3, 32'h55);
    check("load_tos", 64'(tos), 64'h55);
    check("load_s0", 64'(s0), 64'h22);
    do_op(1, 2'd0, 32'd0);
    check("pick0_tos", 64'(tos), 64'h22);
    do_op(1, 2'd0, 32'd3);
    check("pick3_unf", 64'(unf), 64'd1);

    // Underflow on empty pop
    do_reset();
    do_op(1, 2'd2, 32'h0);
    check("unf_flag", 64'(unf), 64'd1);
    check("unf_depth", 64'(depth), 64'd0);
    check("unf_sp", 64'(sp), 64'(D - 1));
    do_op(1, 2'd1, 32'h7);
    check("unf_sticky", 64'(unf), 64'd1);

    // Overflow after DEPTH+1 pushes
    do_reset();
    for (int i = 1; i <= D + 1; i++) do_op(1, 2'd1, 32'(i));
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_depth", 64'(depth), 64'(D));
    check("ovf_tos", 64'(tos), 64'(D + 1));
    check("ovf_s0", 64'(s0), 64'(D));
    check("ovf_sp", 64'(sp), 64'((D + 1) % D));

    // Asynchronous reset between edges in a push burst
    do_reset();
    for (int i = 0; i < 4; i++) do_op(1, 2'd1, 32'hA0 + 32'(i));
    en = 1'b1; op = 2'd1; vi = 32'hBEEF;
    #1 rst = 1'b1;
    #1;
    check("async_tos", 64'(tos), 64'hFFFF_FFFF);
    check("async_sp", 64'(sp), 64'd0);
    check("async_depth", 64'(depth), 64'd0);
    check("async_s0", 64'(s0), 64'd0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    do_op(1, 2'd1, 32'h99);
    check("post_rst_tos", 64'(tos), 64'h99);
    check("post_rst_depth", 64'(depth), 64'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) do_reset();
      do_op($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_stack.md
SS_STACK -- requirements
Module: ss_stack

Interface
REQ-001 Parameter DEPTH, default 64, number of stack memory entries below TOS; power of two, at least 4.
REQ-002 Parameter DSZ, default 32, data width.
REQ-003 Local SSZ = clog2(DEPTH); local CSZ = SSZ+1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  op strobe; op/vi sampled only when en=1.
REQ-007 op  input  2  sop_e: SS_PICK=0, SS_PUSH=1, SS_POP=2, SS_LOAD=3.
REQ-008 vi  input  DSZ  new TOS value for PUSH/LOAD; pick index for PICK (low SSZ bits used).
REQ-009 sp  output  SSZ  stack pointer; index of the memory entry holding s0.
REQ-010 s0  output  DSZ  second-on-stack, registered mirror of mem[sp].
REQ-011 tos  output  DSZ  top-of-stack register.
REQ-012 depth  output  CSZ  count of valid memory entries, 0..DEPTH (TOS not counted).
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 unf  output  1  sticky underflow flag.

Function
REQ-015 Storage: DEPTH x DSZ memory mem[] plus registers tos, s0, sp, depth, ovf, unf; mem read asynchronous, written on clock edge.
REQ-016 en=0: all registers and mem hold.
REQ-017 PUSH: mem[sp+1]<=tos; sp<=sp+1 (mod DEPTH); s0<=tos; tos<=vi; depth<=depth+1.
REQ-018 POP: tos<=s0; sp<=sp-1 (mod DEPTH); s0<=mem[sp-1]; depth<=depth-1.
REQ-019 LOAD: tos<=vi; sp, s0, depth, mem unchanged.
REQ-020 PICK n (n=vi[SSZ-1:0]): tos<=mem[(sp-n) mod DEPTH]; sp, s0, depth, mem unchanged; n=0 copies s0 into tos.
REQ-021 Latency: every op completes in one cycle; results visible on outputs the cycle after the en=1 edge; back-to-back ops every cycle are supported.
REQ-022 Full: PUSH with depth==DEPTH sets ovf<=1, depth stays DEPTH, push still performed (oldest entry overwritten by wrap).
REQ-023 Empty: POP with depth==0 sets unf<=1, depth stays 0, sp still decrements, tos/s0 take the (stale) memory values per REQ-018.
REQ-024 PICK with n>=depth sets unf<=1; the read is still performed.
REQ-025 sp arithmetic is modulo DEPTH; depth arithmetic saturates at 0 and DEPTH.
REQ-026 ovf/unf are sticky; cleared only by rst.
REQ-027 Write and read of the same mem entry in one cycle cannot arise; PUSH writes sp+1, POP reads sp-1.

Reset
REQ-028 rst=1 asynchronously forces sp=0, s0=0, tos=all ones (-1), depth=0, ovf=0, unf=0, independent of clk.
REQ-029 mem contents are not reset and are undefined after reset.
REQ-030 Reset asserted mid-operation aborts that op; no register keeps a partial update; first op after rst deassertion executes normally.

Verification
REQ-031 Reset, then PUSH 0x11, 0x22, 0x33 -> tos=0x33, s0=0x22, sp=3, depth=3, ovf=unf=0.
REQ-032 From REQ-031 state, POP twice -> after 1st tos=0x22, s0=0x11, sp=2; after 2nd tos=0x11, s0=0xFFFFFFFF, sp=1, depth=1.
REQ-033 From REQ-031 state, PICK 1 -> tos=0x11, sp=3, depth=3; then LOAD 0x55 -> tos=0x55, s0=0x22 unchanged.
REQ-034 Reset, then POP -> unf=1, depth=0, sp=DEPTH-1; unf stays 1 through subsequent PUSH.
REQ-035 Reset, then DEPTH+1 PUSHes of 1..DEPTH+1 -> ovf=1, depth=DEPTH, tos=DEPTH+1, s0=DEPTH, sp=(DEPTH+1) mod DEPTH.
REQ-036 Assert rst between clock edges during a PUSH burst -> outputs go to reset values immediately, before the next clk edge.
